mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory/bus slave between N requesters: CPU data port (MEM stage), instruction fetch, and the ASCON accelerator DMA.
- Round-robin arbitration with one outstanding transaction at a time.
- Uses a req/gnt/rvalid handshake on both sides and a read-response watchdog.
- Sits between the pipeline and accelerator masters and the shared SRAM/peripheral bus.

Parameters:
N_MASTERS, 3, number of requesters; index 0 = CPU data, 1 = IF, 2 = ASCON DMA.
ADDR_W, 32, address width.
DATA_W, 32, data width.
TIMEOUT, 16, maximum cycles waited for mem_rvalid after read acceptance; must be ≥2.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
m_req  in  N_MASTERS  per-master request.
m_we  in  N_MASTERS  per-master write enable.
m_size  in  2*N_MASTERS  per-master size: 00 byte, 01 half, 10 word. Passed through unchanged.
m_addr  in  ADDR_W*N_MASTERS  packed addresses; master i at [i*ADDR_W +: ADDR_W].
m_wdata  in  DATA_W*N_MASTERS  packed write data.
m_gnt  out  N_MASTERS  one-hot; high for exactly the cycle the slave accepts master i's request.
m_rvalid  out  N_MASTERS  one-hot read-data-valid pulse.
m_err  out  N_MASTERS  one-hot read-timeout pulse.
m_rdata  out  DATA_W  read data, shared by all masters; valid with m_rvalid.
mem_req  out  1  request to the slave.
mem_we  out  1  write enable to the slave.
mem_size  out  2  size to the slave.
mem_addr  out  ADDR_W  address to the slave.
mem_wdata  out  DATA_W  write data to the slave.
mem_ready  in  1  slave accepts the request this cycle.
mem_rvalid  in  1  slave read data valid.
mem_rdata  in  DATA_W  slave read data.

Behaviour:
- Reset (asynchronous, active-high; clock and reset names are fixed):
  - state = IDLE, rr pointer = 0, owner = 0, watchdog counter = 0, latched request fields = 0.
  - All outputs are 0.
  - Reset mid-transaction aborts it; no gnt, rvalid or err is issued afterwards.
- Master rule: hold m_req, m_we, m_size, m_addr and m_wdata stable until m_gnt is seen. Deassert m_req, or present the next request, in the cycle after m_gnt.
- State IDLE:
  - If m_req != 0, pick the winner: the first asserted bit scanning from the rr pointer upward, wrapping modulo N_MASTERS.
  - Register owner and the winner's we/size/addr/wdata.
  - Set pointer = (winner+1) mod N_MASTERS, then go to ISSUE.
  - If m_req == 0, hold state; the pointer is unchanged.
- State ISSUE:
  - mem_req = 1; mem_we/size/addr/wdata come from the registered fields.
  - mem_req is low in every other state.
  - m_gnt[owner] = mem_ready, combinationally, in this state only.
  - On mem_ready with a write, go to IDLE; the write is complete at acceptance.
  - On mem_ready with a read, clear the counter and go to WAIT.
  - Without mem_ready, stay in ISSUE indefinitely (slave backpressure has no timeout).
- State WAIT:
  - Counter increments every cycle.
  - On mem_rvalid: m_rvalid[owner] = 1 and m_rdata = mem_rdata, both combinational in this cycle; go to IDLE.
  - If mem_rvalid is not seen and counter == TIMEOUT-1: m_err[owner] = 1 for one cycle, m_rdata = 0; go to IDLE.
  - mem_rvalid together with the timeout cycle counts as success: rvalid wins, no err.
- mem_rvalid arriving outside WAIT (late response after a timeout) is ignored. m_rdata is 0 outside rvalid cycles.
- Latency:
  - Minimum write: 2 cycles from m_req to m_gnt (IDLE, then ISSUE with mem_ready=1).
  - Minimum read: m_rvalid 1 cycle after m_gnt.
  - There is always one IDLE cycle between transactions.
- Fairness: a continuously requesting master waits at most N_MASTERS-1 transactions.
- Fairness with all masters requesting: grants cycle 0,1,2,0,...
- Counter width: $clog2(TIMEOUT+1). Wrap-around is impossible because WAIT exits at TIMEOUT-1.
- Simultaneous events: a new m_req during ISSUE or WAIT is only sampled in IDLE. The pointer updates only on selection.

Decomposition:
- Shared package bus_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2.
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD, matching the data memory byte_size.
  - master index constants M_CPU_D, M_IF, M_ASCON.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, binary index, any_req.
  - The pointer register stays in mem_bus_arbiter.

Test Plan:
- Single write: m_req=3'b001, addr=0x100, wdata=0xA5A5_0001, mem_ready=1 → mem_req high 1 cycle after the request with addr 0x100; m_gnt=3'b001 in that cycle; back to IDLE.
- Read with 3-cycle slave latency: master 1 reads 0x40, mem_rvalid 3 cycles after accept with rdata 0x1234_5678 → m_rvalid=3'b010 and m_rdata=0x1234_5678 in that cycle; no err.
- All three masters requesting back-to-back writes → grant order 0,1,2,0,1,2; each master waits ≤2 transactions.
- Backpressure: mem_ready low for 5 cycles in ISSUE → mem_req and fields stable all 5 cycles; m_gnt only in the ready cycle; no err.
- Timeout: read with TIMEOUT=16 and no mem_rvalid → m_err[owner] pulses 16 cycles after accept; a later mem_rvalid is ignored; the next request is arbitrated normally.
- Async reset asserted in WAIT → all outputs 0 immediately; after release, pointer=0 and a request from master 2 alone is granted.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus arbiter:
// state encodings, transfer size codes and master indices.
package bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int M_CPU_D = 0;
  localparam int M_IF    = 1;
  localparam int M_ASCON = 2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT
  } state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and slave-side bus signals of the arbiter.
// slave = arbiter view, master = environment view.
interface mem_bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);

  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS-1:0]        m_we;
  logic [2*N_MASTERS-1:0]      m_size;
  logic [ADDR_W*N_MASTERS-1:0] m_addr;
  logic [DATA_W*N_MASTERS-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_gnt;
  logic [N_MASTERS-1:0]        m_rvalid;
  logic [N_MASTERS-1:0]        m_err;
  logic [DATA_W-1:0]           m_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m_req, m_we, m_size, m_addr, m_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output m_gnt, m_rvalid, m_err, m_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output m_req, m_we, m_size, m_addr, m_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  m_gnt, m_rvalid, m_err, m_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request at or
// above the pointer, wrapping modulo N.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_any = 1'b1;
        o_idx = PW'((int'(i_ptr) + k) % N);
      end
    end
    if (o_any) o_gnt = N'(1) << o_idx;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave between
// several masters, one outstanding transfer, read watchdog.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic clock,
  input  logic reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e r_state, w_next;

  logic [PW-1:0]        r_ptr, r_owner, w_idx;
  logic [N_MASTERS-1:0] w_pgnt, w_own;
  logic                 w_any, w_tmo;
  logic                 r_we, w_sel_we;
  logic [1:0]           r_size, w_sel_size;
  logic [ADDR_W-1:0]    r_addr, w_sel_addr;
  logic [DATA_W-1:0]    r_wdata, w_sel_wdata;
  logic [CW-1:0]        r_cnt;

  rr_pick #(.N(N_MASTERS), .PW(PW)) u_pick (
    .i_req (bus.m_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pgnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_size  = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_pgnt[i]) begin
        w_sel_we    = bus.m_we[i];
        w_sel_size  = bus.m_size[2*i +: 2];
        w_sel_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_own = N_MASTERS'(1) << r_owner;
  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.mem_req    = 1'b0;
    bus.mem_we     = r_we;
    bus.mem_size   = r_size;
    bus.mem_addr   = r_addr;
    bus.mem_wdata  = r_wdata;
    bus.m_gnt      = '0;
    bus.m_rvalid   = '0;
    bus.m_err      = '0;
    bus.m_rdata    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.m_gnt = w_own;
          w_next    = r_we ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the timeout cycle still counts as success.
        if (bus.mem_rvalid) begin
          bus.m_rvalid = w_own;
          bus.m_rdata  = bus.mem_rdata;
          w_next       = S_IDLE;
        end else if (w_tmo) begin
          bus.m_err = w_own;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_owner <= w_idx;
        r_ptr   <= (w_idx == PW'(N_MASTERS - 1)) ? '0 : w_idx + 1'b1;
        r_we    <= w_sel_we;
        r_size  <= w_sel_size;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == S_ISSUE && bus.mem_ready) r_cnt <= '0;
      else if (r_state == S_WAIT)              r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table for
// arbitration order plus sequences for latency, backpressure,
// watchdog and asynchronous reset.
module tb_mem_bus_arbiter;
  import bus_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arbiter #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  gnt;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [2:0]  rv;
    logic [2:0]  er;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic [2:0] req;
    logic [2:0] exp;
  } vec_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  acc_t mon_a;
  rsp_t mon_r;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.mem_req, bus.mem_we, bus.mem_size, bus.mem_addr,
            bus.mem_wdata, bus.m_gnt, bus.m_rvalid, bus.m_err,
            bus.m_rdata};
  endfunction

  function automatic acc_t mk_acc(input int m, input logic we,
                                  input logic [1:0] sz,
                                  input logic [31:0] a,
                                  input logic [31:0] d);
    acc_t x;
    x.gnt   = 3'b001 << m;
    x.we    = we;
    x.size  = sz;
    x.addr  = a;
    x.wdata = d;
    return x;
  endfunction

  task automatic set_m(input int m, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    bus.m_we[m]            = we;
    bus.m_size[2*m +: 2]   = sz;
    bus.m_addr[m*AW +: AW] = a;
    bus.m_wdata[m*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_acc(input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clock);
      if (bus.mem_req && bus.mem_ready) got = 1'b1;
    end
    chk(nm, got, 1);
  endtask

  // Scoreboard: every accepted request and every response is popped
  // from the queue the driver filled.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.mem_req && bus.mem_ready) begin
        chk("acc_pending", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          mon_a = acc_q.pop_front();
          chk("accept", {bus.m_gnt, bus.mem_we, bus.mem_size,
                         bus.mem_addr, bus.mem_wdata}, mon_a);
        end
      end else begin
        chk("gnt_quiet", bus.m_gnt, 0);
      end
      if (|bus.m_rvalid || |bus.m_err) begin
        chk("rsp_pending", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          chk("response", {bus.m_rvalid, bus.m_err, bus.m_rdata}, mon_r);
        end
      end else begin
        chk("rdata_quiet", bus.m_rdata, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  vec_t tv[8];
  int   w, m, r, lat;
  rsp_t rs;

  initial begin
    tv[0] = '{3'b111, 3'b010};
    tv[1] = '{3'b111, 3'b100};
    tv[2] = '{3'b111, 3'b001};
    tv[3] = '{3'b101, 3'b100};
    tv[4] = '{3'b110, 3'b010};
    tv[5] = '{3'b011, 3'b001};
    tv[6] = '{3'b010, 3'b010};
    tv[7] = '{3'b100, 3'b100};

    bus.m_req      = '0;
    bus.m_we       = '0;
    bus.m_size     = '0;
    bus.m_addr     = '0;
    bus.m_wdata    = '0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", all_outs(), 0);
    reset = 1'b0;

    // Single write, minimum latency
    tick();
    set_m(0, 1'b1, SZ_WORD, 32'h100, 32'hA5A5_0001);
    bus.m_req = 3'b001;
    acc_q.push_back(mk_acc(0, 1'b1, SZ_WORD, 32'h100, 32'hA5A5_0001));
    @(negedge clock);
    chk("wr_idle_cycle", bus.mem_req, 0);
    @(negedge clock);
    chk("wr_issue_cycle", {bus.mem_req, bus.m_gnt, bus.mem_addr},
        {1'b1, 3'b001, 32'h100});
    tick();
    bus.m_req = '0;
    @(negedge clock);
    chk("wr_back_idle", bus.mem_req, 0);

    // Arbitration table (pointer is 1 here)
    for (int v = 0; v < 8; v++) begin
      tick();
      for (int i = 0; i < N; i++)
        set_m(i, 1'b1, SZ_WORD, 32'h1000 + v*16 + i*4,
              32'hC0DE_0000 + v*16 + i);
      bus.m_req = tv[v].req;
      w = 0;
      for (int i = 0; i < N; i++) if (tv[v].exp[i]) w = i;
      acc_q.push_back(mk_acc(w, 1'b1, SZ_WORD, 32'h1000 + v*16 + w*4,
                             32'hC0DE_0000 + v*16 + w));
      wait_acc($sformatf("vec%0d_acc", v));
      tick();
      bus.m_req = '0;
    end

    // All masters continuously requesting: 0,1,2,0,1,2
    tick();
    for (int i = 0; i < N; i++)
      set_m(i, 1'b1, SZ_HALF, 32'h2000 + i*4, i);
    for (int rr = 0; rr < 2; rr++)
      for (int i = 0; i < N; i++)
        acc_q.push_back(mk_acc(i, 1'b1, SZ_HALF,
                               32'h2000 + rr*16 + i*4, rr*16 + i));
    bus.m_req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      wait_acc($sformatf("rr%0d_acc", g));
      tick();
      m = g % N;
      r = g / N;
      if (r == 0)
        set_m(m, 1'b1, SZ_HALF, 32'h2000 + 16 + m*4, 16 + m);
      else
        bus.m_req[m] = 1'b0;
    end

    // Read, 3-cycle slave latency (pointer 0 -> master 1 wins)
    set_m(1, 1'b0, SZ_WORD, 32'h40, 32'h0);
    bus.m_req = 3'b010;
    acc_q.push_back(mk_acc(1, 1'b0, SZ_WORD, 32'h40, 32'h0));
    wait_acc("rd_acc");
    tick();
    bus.m_req = '0;
    tick();
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    rs = '{3'b010, 3'b000, 32'h1234_5678};
    rsp_q.push_back(rs);
    @(negedge clock);
    chk("rd_rvalid", {bus.m_rvalid, bus.m_err, bus.m_rdata}, rs);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // Backpressure: 5 cycles of mem_ready low (pointer 2)
    bus.mem_ready = 1'b0;
    set_m(2, 1'b1, SZ_BYTE, 32'h300, 32'h77);
    bus.m_req = 3'b100;
    acc_q.push_back(mk_acc(2, 1'b1, SZ_BYTE, 32'h300, 32'h77));
    @(negedge clock);
    chk("bp_idle", bus.mem_req, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("bp_hold%0d", k),
          {bus.mem_req, bus.m_gnt, bus.mem_we, bus.mem_size,
           bus.mem_addr, bus.mem_wdata},
          {1'b1, 3'b000, 1'b1, SZ_BYTE, 32'h300, 32'h77});
    end
    tick();
    bus.mem_ready = 1'b1;
    @(negedge clock);
    chk("bp_gnt", bus.m_gnt, 3'b100);
    tick();
    bus.m_req = '0;

    // Read timeout (pointer 0 -> master 0)
    set_m(0, 1'b0, SZ_WORD, 32'h80, 32'h5);
    bus.m_req = 3'b001;
    acc_q.push_back(mk_acc(0, 1'b0, SZ_WORD, 32'h80, 32'h5));
    wait_acc("tmo_acc");
    rsp_q.push_back('{3'b000, 3'b001, 32'h0});
    tick();
    bus.m_req = '0;
    lat = 0;
    for (int k = 1; k <= TO + 4 && lat == 0; k++) begin
      @(negedge clock);
      if (|bus.m_err) lat = k;
    end
    chk("tmo_latency", lat, TO);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("late_ignored", {bus.m_rvalid, bus.m_err, bus.m_rdata}, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // Normal arbitration after timeout (pointer 1)
    set_m(1, 1'b1, SZ_WORD, 32'h500, 32'h51);
    set_m(2, 1'b1, SZ_WORD, 32'h600, 32'h62);
    bus.m_req = 3'b110;
    acc_q.push_back(mk_acc(1, 1'b1, SZ_WORD, 32'h500, 32'h51));
    wait_acc("post_tmo_acc");
    tick();
    bus.m_req = '0;

    // Async reset during WAIT (pointer 2 -> master 0 wins)
    set_m(0, 1'b0, SZ_WORD, 32'h90, 32'h0);
    bus.m_req = 3'b001;
    acc_q.push_back(mk_acc(0, 1'b0, SZ_WORD, 32'h90, 32'h0));
    wait_acc("rst_rd_acc");
    tick();
    bus.m_req = '0;
    tick();
    #2;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_0001;
    reset = 1'b1;
    #1;
    chk("rst_async", all_outs(), 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_quiet", {bus.m_rvalid, bus.m_err, bus.mem_req}, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // Pointer back to 0: master 0 beats master 1
    set_m(0, 1'b1, SZ_WORD, 32'h700, 32'h70);
    set_m(1, 1'b1, SZ_WORD, 32'h710, 32'h71);
    bus.m_req = 3'b011;
    acc_q.push_back(mk_acc(0, 1'b1, SZ_WORD, 32'h700, 32'h70));
    wait_acc("rst_ptr_acc");
    tick();
    bus.m_req = '0;

    set_m(2, 1'b1, SZ_WORD, 32'h720, 32'h72);
    bus.m_req = 3'b100;
    acc_q.push_back(mk_acc(2, 1'b1, SZ_WORD, 32'h720, 32'h72));
    wait_acc("rst_m2_acc");
    tick();
    bus.m_req = '0;

    repeat (3) @(negedge clock);
    chk("acc_q_empty", acc_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
